// File: rtl/sram_host_arbiter.sv
// N-host arbiter onto one single-port SRAM with same-cycle grant,
// round-robin or fixed priority, and a latency-matched response pipe.
module sram_host_arbiter #(
  parameter int unsigned NumHosts = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter logic [AddrWidth-1:0] MemStart = '0,
  parameter int unsigned MemSize = 65536,
  parameter int unsigned MemLatency = 1,
  parameter bit RoundRobin = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumHosts-1:0]              host_req_i,
  input  logic [NumHosts-1:0]              host_we_i,
  input  logic [NumHosts*DataWidth/8-1:0]  host_be_i,
  input  logic [NumHosts*AddrWidth-1:0]    host_addr_i,
  input  logic [NumHosts*DataWidth-1:0]    host_wdata_i,
  output logic [NumHosts-1:0]              host_gnt_o,
  output logic [NumHosts-1:0]              host_rvalid_o,
  output logic [NumHosts-1:0]              host_err_o,
  output logic [DataWidth-1:0]             host_rdata_o,
  output logic                             mem_req_o,
  output logic                             mem_we_o,
  output logic [DataWidth/8-1:0]           mem_be_o,
  output logic [AddrWidth-1:0]             mem_addr_o,
  output logic [DataWidth-1:0]             mem_wdata_o,
  input  logic [DataWidth-1:0]             mem_rdata_i
);

  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned IdxW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam logic [AddrWidth-1:0] OffMask = AddrWidth'(MemSize - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumHosts - 1);

  if (MemSize == 0 || (MemSize & (MemSize - 1)) != 0) begin : g_bad_size
    $error("MemSize must be a power of two");
  end
  if (MemLatency < 1) begin : g_bad_lat
    $error("MemLatency must be at least 1");
  end
  if ((MemStart & OffMask) != '0) begin : g_bad_base
    $error("MemStart must be aligned to MemSize");
  end

  logic [IdxW-1:0]      ptr;
  logic [IdxW-1:0]      win_idx;
  logic                 win_valid;
  logic                 active;
  logic                 hit;
  logic [AddrWidth-1:0] win_addr;

  logic [MemLatency-1:0]           pipe_valid;
  logic [MemLatency-1:0]           pipe_err;
  logic [MemLatency-1:0][IdxW-1:0] pipe_idx;

  // Search from the pointer (RR) or from host 0 (fixed), wrapping.
  always_comb begin : p_arb
    int j;
    logic [IdxW-1:0] cand;
    j = 0;
    cand = '0;
    win_valid = 1'b0;
    win_idx = '0;
    for (int k = 0; k < int'(NumHosts); k++) begin
      j = RoundRobin ? int'(ptr) + k : k;
      if (j >= int'(NumHosts)) j = j - int'(NumHosts);
      cand = IdxW'(j);
      if (!win_valid && host_req_i[cand]) begin
        win_valid = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign active   = rst_ni & win_valid;
  assign win_addr = host_addr_i[win_idx*AddrWidth +: AddrWidth];
  assign hit      = (win_addr & ~OffMask) == MemStart;

  always_comb begin
    host_gnt_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (active) begin
      host_gnt_o[win_idx] = 1'b1;
      if (hit) begin
        mem_req_o   = 1'b1;
        mem_we_o    = host_we_i[win_idx];
        mem_be_o    = host_be_i[win_idx*BeWidth +: BeWidth];
        mem_addr_o  = win_addr & OffMask;
        mem_wdata_o = host_wdata_i[win_idx*DataWidth +: DataWidth];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr        <= '0;
      pipe_valid <= '0;
      pipe_err   <= '0;
      pipe_idx   <= '0;
    end else begin
      pipe_valid[0] <= win_valid;
      pipe_idx[0]   <= win_idx;
      pipe_err[0]   <= win_valid & ~hit;
      for (int s = 1; s < int'(MemLatency); s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_idx[s]   <= pipe_idx[s-1];
        pipe_err[s]   <= pipe_err[s-1];
      end
      if (win_valid) begin
        ptr <= (win_idx == LastIdx) ? '0 : win_idx + 1'b1;
      end
    end
  end

  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    if (pipe_valid[MemLatency-1]) begin
      host_rvalid_o[pipe_idx[MemLatency-1]] = 1'b1;
      host_err_o[pipe_idx[MemLatency-1]] = pipe_err[MemLatency-1];
      if (!pipe_err[MemLatency-1]) host_rdata_o = mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_sram_host_arbiter.sv
// Bench for sram_host_arbiter: a 2-host RR latency-1 instance and a
// 3-host fixed-priority latency-3 instance, each on a small SRAM model.
module tb_sram_host_arbiter;

  typedef struct {
    int          host;
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  logic [1:0]  a_req, a_we, a_gnt, a_rvalid, a_err;
  logic [7:0]  a_be;
  logic [63:0] a_addr, a_wdata;
  logic [31:0] a_rdata, a_maddr, a_mwdata, a_mrdata;
  logic        a_mreq, a_mwe;
  logic [3:0]  a_mbe;

  logic [2:0]  b_req, b_we, b_gnt, b_rvalid, b_err;
  logic [11:0] b_be;
  logic [95:0] b_addr, b_wdata;
  logic [31:0] b_rdata, b_maddr, b_mwdata, b_mrdata;
  logic        b_mreq, b_mwe;
  logic [3:0]  b_mbe;

  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [31:0] b_rd1, b_rd2;

  sram_host_arbiter #(
    .NumHosts(2), .MemLatency(1), .RoundRobin(1'b1)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(a_req), .host_we_i(a_we), .host_be_i(a_be),
    .host_addr_i(a_addr), .host_wdata_i(a_wdata),
    .host_gnt_o(a_gnt), .host_rvalid_o(a_rvalid), .host_err_o(a_err),
    .host_rdata_o(a_rdata),
    .mem_req_o(a_mreq), .mem_we_o(a_mwe), .mem_be_o(a_mbe),
    .mem_addr_o(a_maddr), .mem_wdata_o(a_mwdata), .mem_rdata_i(a_mrdata)
  );

  sram_host_arbiter #(
    .NumHosts(3), .MemLatency(3), .RoundRobin(1'b0)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(b_req), .host_we_i(b_we), .host_be_i(b_be),
    .host_addr_i(b_addr), .host_wdata_i(b_wdata),
    .host_gnt_o(b_gnt), .host_rvalid_o(b_rvalid), .host_err_o(b_err),
    .host_rdata_o(b_rdata),
    .mem_req_o(b_mreq), .mem_we_o(b_mwe), .mem_be_o(b_mbe),
    .mem_addr_o(b_maddr), .mem_wdata_o(b_mwdata), .mem_rdata_i(b_mrdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM models: read data appears MemLatency cycles after the request;
  // non-read cycles return a marker word.
  always @(posedge clk) begin
    if (a_mreq && a_mwe) begin
      for (int k = 0; k < 4; k++)
        if (a_mbe[k]) mem_a[a_maddr[9:2]][8*k +: 8] <= a_mwdata[8*k +: 8];
    end
    a_mrdata <= (a_mreq && !a_mwe) ? mem_a[a_maddr[9:2]] : 32'hDEAD_BEEF;
    b_rd1 <= (b_mreq && !b_mwe) ? mem_b[b_maddr[9:2]] : 32'hDEAD_BEEF;
    b_rd2 <= b_rd1;
    b_mrdata <= b_rd2;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [2:0] g);
    return g[2] ? 2 : (g[1] ? 1 : 0);
  endfunction

  // Monitors: pop the oldest expected response whenever rvalid shows.
  always @(negedge clk) begin
    if (a_rvalid != '0) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL a_unexpected_rvalid: got %b required 00", a_rvalid);
      end else begin
        ea = qa.pop_front();
        chk("a_rvalid", 64'(a_rvalid), 64'(2'b01 << ea.host));
        chk("a_err", 64'(a_err), ea.err ? 64'(2'b01 << ea.host) : 64'd0);
        chk("a_rdata", 64'(a_rdata), 64'(ea.data));
        chk("a_rcycle", 64'(cyc), 64'(ea.cyc));
      end
    end else begin
      chk("a_idle_resp", 64'({a_err, a_rdata}), 64'd0);
    end
  end

  always @(negedge clk) begin
    if (b_rvalid != '0) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL b_unexpected_rvalid: got %b required 000", b_rvalid);
      end else begin
        eb = qb.pop_front();
        chk("b_rvalid", 64'(b_rvalid), 64'(3'b001 << eb.host));
        chk("b_err", 64'(b_err), eb.err ? 64'(3'b001 << eb.host) : 64'd0);
        chk("b_rdata", 64'(b_rdata), 64'(eb.data));
        chk("b_rcycle", 64'(cyc), 64'(eb.cyc));
      end
    end
  end

  task automatic a_issue(input logic [1:0] req, input logic [1:0] gnt,
                         input logic mreq, input logic [31:0] maddr,
                         input logic [31:0] data);
    a_req = req;
    @(negedge clk);
    chk("a_gnt", 64'(a_gnt), 64'(gnt));
    chk("a_mreq", 64'(a_mreq), 64'(mreq));
    if (mreq) chk("a_maddr", 64'(a_maddr), 64'(maddr));
    if (gnt != '0)
      qa.push_back('{host: idx_of({1'b0, gnt}), err: !mreq,
                     data: data, cyc: cyc + 1});
    @(posedge clk);
    #1;
    a_req = '0;
  endtask

  task automatic b_issue(input logic [2:0] req, input logic [2:0] gnt,
                         input logic [31:0] maddr, input logic [31:0] data);
    b_req = req;
    @(negedge clk);
    chk("b_gnt", 64'(b_gnt), 64'(gnt));
    chk("b_mreq", 64'(b_mreq), 64'd1);
    chk("b_maddr", 64'(b_maddr), 64'(maddr));
    qb.push_back('{host: idx_of(gnt), err: 1'b0, data: data, cyc: cyc + 3});
    @(posedge clk);
    #1;
    b_req = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'hC0DE_0000 | 32'(i);
      mem_b[i] = 32'hC0DE_0000 | 32'(i);
    end
    rst_n = 1'b0;
    a_req = 2'b11;
    a_we = '0;
    a_be = '1;
    a_addr = {32'h0000_0044, 32'h0000_0020};
    a_wdata = '0;
    b_req = 3'b111;
    b_we = '0;
    b_be = '1;
    b_addr = {32'h0000_0034, 32'h0000_0030, 32'h0000_0038};
    b_wdata = '0;

    #12;
    chk("rst_a_gnt", 64'(a_gnt), 64'd0);
    chk("rst_b_gnt", 64'(b_gnt), 64'd0);
    chk("rst_a_mem", 64'({a_mreq, a_maddr}), 64'd0);
    chk("rst_b_mem", 64'({b_mreq, b_maddr}), 64'd0);
    chk("rst_rvalid", 64'({a_rvalid, b_rvalid}), 64'd0);
    a_req = '0;
    b_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_a_mem", 64'({a_gnt, a_mreq, a_maddr}), 64'd0);
    @(posedge clk);
    #1;

    // RR alternation, both hosts reading continuously
    a_issue(2'b11, 2'b01, 1'b1, 32'h20, 32'hC0DE_0008);
    a_issue(2'b11, 2'b10, 1'b1, 32'h44, 32'hC0DE_0011);
    a_issue(2'b11, 2'b01, 1'b1, 32'h20, 32'hC0DE_0008);
    a_issue(2'b11, 2'b10, 1'b1, 32'h44, 32'hC0DE_0011);

    // Host 1 byte write to 0x10, lane 2
    a_we = 2'b10;
    a_be = {4'b0100, 4'b1111};
    a_addr[63:32] = 32'h0000_0010;
    a_wdata[63:32] = 32'hAABB_CCDD;
    a_req = 2'b10;
    @(negedge clk);
    chk("wr_gnt", 64'(a_gnt), 64'b10);
    chk("wr_mreq_we", 64'({a_mreq, a_mwe}), 64'b11);
    chk("wr_maddr", 64'(a_maddr), 64'h10);
    chk("wr_mbe", 64'(a_mbe), 64'b0100);
    chk("wr_mwdata", 64'(a_mwdata), 64'hAABB_CCDD);
    qa.push_back('{host: 1, err: 1'b0, data: 32'hDEAD_BEEF, cyc: cyc + 1});
    @(posedge clk);
    #1;
    a_req = '0;
    a_we = '0;
    a_be = '1;
    a_issue(2'b10, 2'b10, 1'b1, 32'h10, 32'hC0BB_0004);

    // Unmapped address: grant, no SRAM access, error response
    a_addr[31:0] = 32'h0001_0000;
    a_issue(2'b01, 2'b01, 1'b0, 32'h0, 32'h0);
    a_addr[31:0] = 32'h0000_0020;

    // Fixed priority: host 2 starved by host 1, host 0 preempts
    b_issue(3'b110, 3'b010, 32'h30, 32'hC0DE_000C);
    b_issue(3'b110, 3'b010, 32'h30, 32'hC0DE_000C);
    b_issue(3'b110, 3'b010, 32'h30, 32'hC0DE_000C);
    b_issue(3'b111, 3'b001, 32'h38, 32'hC0DE_000E);

    // Latency 3: four back-to-back reads from alternating hosts
    b_addr[31:0] = 32'h0;
    b_addr[63:32] = 32'h4;
    b_issue(3'b001, 3'b001, 32'h0, 32'hC0DE_0000);
    b_issue(3'b010, 3'b010, 32'h4, 32'hC0DE_0001);
    b_addr[31:0] = 32'h8;
    b_addr[63:32] = 32'hC;
    b_issue(3'b001, 3'b001, 32'h8, 32'hC0DE_0002);
    b_issue(3'b010, 3'b010, 32'hC, 32'hC0DE_0003);
    repeat (6) @(posedge clk);
    #1;

    // Reset with two responses in flight on the latency-3 instance
    b_addr[95:64] = 32'h40;
    b_addr[31:0] = 32'h44;
    b_issue(3'b100, 3'b100, 32'h40, 32'hC0DE_0010);
    b_issue(3'b001, 3'b001, 32'h44, 32'hC0DE_0011);
    qb.delete();
    rst_n = 1'b0;
    a_req = 2'b11;
    b_req = 3'b111;
    #1;
    chk("arst_gnt", 64'({a_gnt, b_gnt}), 64'd0);
    chk("arst_mreq", 64'({a_mreq, b_mreq}), 64'd0);
    chk("arst_rvalid", 64'({a_rvalid, b_rvalid}), 64'd0);
    chk("arst_rdata", 64'({a_rdata, b_rdata}), 64'd0);
    repeat (2) @(posedge clk);
    a_req = '0;
    b_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    a_issue(2'b11, 2'b01, 1'b1, 32'h20, 32'hC0DE_0008);
    repeat (6) @(posedge clk);
    #1;
    chk("a_pending", 64'(qa.size()), 64'd0);
    chk("b_pending", 64'(qb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_host_arbiter.md
Name: sram_host_arbiter

Overview:
- Parametrised N-host arbiter connecting several Ibex-protocol hosts to one single-port SRAM. Hosts are instruction fetch, data, and later DMA/debug.
- Successor to the fixed two-port instr-over-data mux with registered grants. Adds:
  - configurable host count;
  - round-robin or fixed priority;
  - same-cycle grant;
  - configurable SRAM read latency with pipelined responses;
  - error responses for unmapped addresses.
- Sits between the core/bus hosts and the SRAM macro in FPGA top levels.

Parameters:
- NumHosts, 2, number of host ports (>=1)
- AddrWidth, 32, host address width
- DataWidth, 32, data width (multiple of 8)
- MemStart, 32'h00000000, SRAM base address, aligned to MemSize
- MemSize, 65536, SRAM size in bytes, power of two
- MemLatency, 1, cycles from mem_req_o to valid mem_rdata_i (>=1)
- RoundRobin, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- host_req_i  in  NumHosts  request per host
- host_we_i  in  NumHosts  write enable per host
- host_be_i  in  NumHosts*DataWidth/8  byte enables, host i at slice i
- host_addr_i  in  NumHosts*AddrWidth  byte addresses
- host_wdata_i  in  NumHosts*DataWidth  write data
- host_gnt_o  out  NumHosts  grant, one-hot or zero
- host_rvalid_o  out  NumHosts  response valid, one-hot or zero
- host_err_o  out  NumHosts  response error, qualified by host_rvalid_o
- host_rdata_o  out  DataWidth  shared read data, qualified by host_rvalid_o
- mem_req_o  out  1  SRAM access
- mem_we_o  out  1  SRAM write
- mem_be_o  out  DataWidth/8  SRAM byte enables
- mem_addr_o  out  AddrWidth  byte offset into SRAM (addr & (MemSize-1))
- mem_wdata_o  out  DataWidth  SRAM write data
- mem_rdata_i  in  DataWidth  SRAM read data

Behaviour:
- Reset values: all outputs 0, priority pointer 0, response pipeline empty.
- Arbitration (combinational):
  - at most one winner per cycle among hosts with req=1;
  - host_gnt_o[winner]=1 in the same cycle; every other bit is 0.
- Fixed mode: lowest requesting index wins.
- RR mode:
  - search starts at the pointer and wraps modulo NumHosts;
  - on a grant, pointer <= (winner+1) mod NumHosts;
  - on cycles with no request, the pointer holds.
- Decode:
  - hit = ((addr & ~(MemSize-1)) == MemStart);
  - winner hit: mem_req_o=1, and mem_we/be/addr/wdata_o come from the winner;
  - winner miss: grant still given, mem_req_o=0;
  - no winner: mem_* outputs are 0.
- Response pipeline: MemLatency-deep shift register of {valid, host index, err}, loaded on every grant.
  - host_rvalid_o[idx] asserts exactly MemLatency cycles after the grant cycle, for one cycle.
  - Holds for reads and writes alike.
  - Hit: err=0, host_rdata_o = mem_rdata_i.
  - Miss: err=1, host_rdata_o = 0.
  - Cycles with no response: host_rdata_o = 0.
- Throughput:
  - one grant per cycle back-to-back;
  - up to MemLatency transactions in flight;
  - no response backpressure; hosts must accept rvalid.
- Ordering: responses return in grant order.
- Request after grant: a host holding req after its grant is a new request.
- Reset mid-operation: in-flight responses are discarded (no rvalid after reset release) and the pointer returns to 0.
- Elaboration errors:
  - MemSize not a power of two;
  - MemLatency < 1;
  - MemStart not aligned to MemSize.

Test Plan:
- NumHosts=2, RR, MemLatency=1; both hosts request reads continuously → grants alternate 0,1,0,1 starting host 0; each rvalid one cycle after its grant with matching preloaded data.
- RoundRobin=0, NumHosts=3; hosts 1 and 2 request persistently → host 1 granted every cycle, host 2 starved; host 0 request preempts host 1 the same cycle.
- Host 1 write to 0x0000_0010 with be=4'b0100, wdata=0xAABBCCDD → mem_req_o=1, mem_we_o=1, mem_addr_o=0x10, mem_be_o=4'b0100; read-back returns byte 0xBB in bits 23:16.
- Read of 0x0001_0000 (MemSize=64kB) → gnt same cycle, mem_req_o=0, rvalid+err=1, rdata=0 after MemLatency cycles.
- MemLatency=3; four back-to-back reads from alternating hosts → rvalids on cycles 3,4,5,6 after the first grant, routed to the correct hosts in order.
- Assert rst_ni low with 2 responses in flight → all outputs 0 asynchronously; no rvalid after release; the first post-reset RR grant goes to host 0.
